receptor_matrizes: RTL and testbench
====================================

RECEPTOR_MATRIZES -- requirements
Module: receptor_matrizes

Interface
REQ-001 SHALL have parameter N_ELEM, default 25, meaning number of matrix elements received per operation.
REQ-002 SHALL have parameter W_ELEM, default 8, meaning bit width of one element.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port entrada, input, 32 bits, the HPS-to-FPGA word:
- [7:0] element A
- [15:8] element B
- [18:16] opcode
- [20:19] tamanho
- [31] request (req)
- other bits ignored
REQ-006 SHALL have port ack, output, 1 bit, the handshake acknowledge returned to HPS (FPGA-HPS bit 31).
REQ-007 SHALL have port consumir, input, 1 bit, a downstream pulse that releases a completed frame.
REQ-008 SHALL have ports matriz1 and matriz2, output, N_ELEM*W_ELEM bits each; element k occupies bits [k*W_ELEM +: W_ELEM].
REQ-009 SHALL have port opcode, output, 3 bits, and port tamanho, output, 2 bits, both taken from the frame's first word.
REQ-010 SHALL have port valido, output, 1 bit; high while a complete frame is held.
REQ-011 SHALL have port erro_op, output, 1 bit; sticky flag for opcode/tamanho inconsistency within a frame.
REQ-012 SHALL have port indice, output, 5 bits, the index of the element currently expected.

Function
REQ-013 SHALL implement three states: ESPERA_REQ, ESPERA_SOLTA, PRONTO.
REQ-014 In ESPERA_REQ with req sampled 1, the edge SHALL:
- write entrada[7:0] to matriz1 element indice
- write entrada[15:8] to matriz2 element indice
- set ack=1
- go to ESPERA_SOLTA
REQ-015 Capture on word indice 0 SHALL also latch opcode=entrada[18:16] and tamanho=entrada[20:19].
REQ-016 Capture on word indice>0 whose [20:16] differs from the latched opcode/tamanho SHALL set erro_op=1; elements are still stored.
REQ-017 In ESPERA_SOLTA, req=1 SHALL hold all state; ack stays 1; no further capture.
REQ-018 In ESPERA_SOLTA with req sampled 0 and indice<N_ELEM-1, the edge SHALL set ack=0, increment indice and go to ESPERA_REQ.
REQ-019 In ESPERA_SOLTA with req sampled 0 and indice=N_ELEM-1, the edge SHALL set ack=0, set valido=1, leave indice at N_ELEM-1 and go to PRONTO.
REQ-020 Latency SHALL be one cycle from req sampled to ack change.
REQ-021 In PRONTO, req SHALL be ignored: ack stays 0 and no capture occurs.
REQ-022 In PRONTO, consumir=1 SHALL on the next edge:
- set valido=0, indice=0, erro_op=0
- go to ESPERA_REQ
- leave matriz1, matriz2, opcode and tamanho unchanged
REQ-023 consumir outside PRONTO SHALL be ignored.
REQ-024 consumir and req both high in PRONTO SHALL process only consumir; req is captured no earlier than the following cycle.
REQ-025 Element writes SHALL touch only the addressed W_ELEM slice; all other slices hold their values.
REQ-026 indice SHALL never exceed N_ELEM-1.
REQ-027 Matrix contents outside PRONTO SHALL be treated as partial; only valido qualifies them.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL take reset values on that edge, overriding all other inputs:
- state ESPERA_REQ
- ack=0, valido=0, erro_op=0, indice=0
- matriz1=0, matriz2=0
- opcode=3'b111, tamanho=0
REQ-029 Reset asserted mid-frame (any state) SHALL discard the partial frame; the next req starts at element 0.
REQ-030 Reset held high SHALL keep ack=0 regardless of req.

Verification
REQ-031 Full frame: 25 four-phase handshakes; word k carries A=k, B=100+k, op=3'b010, tam=2'b11 -> each ack rises 1 cycle after req and falls 1 cycle after req drops; after the 25th drop valido=1, matriz1 byte k=k, matriz2 byte k=100+k, opcode=2, tamanho=3, erro_op=0.
REQ-032 Opcode mismatch: frame as REQ-031, but word 7 carries op=3'b001 -> erro_op=1 from the word-7 capture edge through PRONTO; opcode stays 2; consumir clears erro_op.
REQ-033 Back-pressure: in PRONTO, assert req for 10 cycles with A=0xFF -> ack stays 0 and matriz1 is unchanged; assert consumir together with req -> valido=0 next edge; ack=1 one edge later; element 0 = 0xFF.
REQ-034 Reset mid-frame: reset pulsed after 12 words while ack=1 -> next edge ack=0, indice=0, matriz1=0, opcode=7; a following full frame completes correctly.
REQ-035 Long req hold: keep req high 20 cycles after ack rises -> only one capture occurs, indice unchanged until req drops.

Source files
------------

// File: rtl/receptor_matrizes.sv
// receptor_matrizes
// Receives two matrices from the HPS one element pair per four-phase
// handshake and holds the completed frame until downstream releases it.
//
// Ports:
//   clk       - system clock; all state changes on its rising edge
//   reset     - synchronous, active-high reset
//   entrada   - HPS word: [7:0] element A, [15:8] element B, [18:16] opcode,
//               [20:19] tamanho, [31] req; other bits ignored
//   ack       - handshake acknowledge returned to the HPS
//   consumir  - pulse from downstream that releases a held frame
//   matriz1   - elements A, element k at [k*W_ELEM +: W_ELEM]
//   matriz2   - elements B, same layout
//   opcode    - opcode latched from the frame's first word
//   tamanho   - tamanho latched from the frame's first word
//   valido    - high while a complete frame is held
//   erro_op   - sticky: a later word disagreed with the first word's opcode/tamanho
//   indice    - index of the element currently expected
module receptor_matrizes #(
  parameter int N_ELEM = 25,
  parameter int W_ELEM = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                entrada,
  output logic                       ack,
  input  logic                       consumir,
  output logic [N_ELEM*W_ELEM-1:0]   matriz1,
  output logic [N_ELEM*W_ELEM-1:0]   matriz2,
  output logic [2:0]                 opcode,
  output logic [1:0]                 tamanho,
  output logic                       valido,
  output logic                       erro_op,
  output logic [4:0]                 indice
);

  typedef enum logic [1:0] {
    ESPERA_REQ   = 2'd0,
    ESPERA_SOLTA = 2'd1,
    PRONTO       = 2'd2
  } estado_t;

  localparam logic [4:0] ULTIMO = 5'(N_ELEM - 1);

  estado_t                     estado_r, estado_s;
  logic                        ack_r, ack_s;
  logic                        valido_r, valido_s;
  logic                        erro_op_r, erro_op_s;
  logic [4:0]                  indice_r, indice_s;
  logic [N_ELEM*W_ELEM-1:0]    matriz1_r, matriz1_s;
  logic [N_ELEM*W_ELEM-1:0]    matriz2_r, matriz2_s;
  logic [2:0]                  opcode_r, opcode_s;
  logic [1:0]                  tamanho_r, tamanho_s;
  logic                        req_s;
  logic [4:0]                  campo_s;

  assign req_s   = entrada[31];
  // {tamanho, opcode} as carried in bits [20:16] of the word
  assign campo_s = entrada[20:16];

  // Next-state and next-output logic for the handshake FSM
  always_comb begin
    estado_s  = estado_r;
    ack_s     = ack_r;
    valido_s  = valido_r;
    erro_op_s = erro_op_r;
    indice_s  = indice_r;
    matriz1_s = matriz1_r;
    matriz2_s = matriz2_r;
    opcode_s  = opcode_r;
    tamanho_s = tamanho_r;
    case (estado_r)
      ESPERA_REQ: begin
        if (req_s) begin
          matriz1_s[int'(indice_r)*W_ELEM +: W_ELEM] = W_ELEM'(entrada[7:0]);
          matriz2_s[int'(indice_r)*W_ELEM +: W_ELEM] = W_ELEM'(entrada[15:8]);
          ack_s    = 1'b1;
          estado_s = ESPERA_SOLTA;
          if (indice_r == 5'd0) begin
            opcode_s  = entrada[18:16];
            tamanho_s = entrada[20:19];
          end else if (campo_s != {tamanho_r, opcode_r}) begin
            // Element is still stored; only the flag records the disagreement
            erro_op_s = 1'b1;
          end else begin
            erro_op_s = erro_op_r;
          end
        end else begin
          estado_s = ESPERA_REQ;
        end
      end
      ESPERA_SOLTA: begin
        if (!req_s) begin
          ack_s = 1'b0;
          if (indice_r == ULTIMO) begin
            // Last element: indice stays put so it never passes N_ELEM-1
            valido_s = 1'b1;
            estado_s = PRONTO;
          end else begin
            indice_s = indice_r + 5'd1;
            estado_s = ESPERA_REQ;
          end
        end else begin
          estado_s = ESPERA_SOLTA;
        end
      end
      PRONTO: begin
        // req is ignored here; a concurrent req is only seen from ESPERA_REQ
        if (consumir) begin
          valido_s  = 1'b0;
          indice_s  = 5'd0;
          erro_op_s = 1'b0;
          estado_s  = ESPERA_REQ;
        end else begin
          estado_s = PRONTO;
        end
      end
      default: begin
        estado_s = ESPERA_REQ;
        ack_s    = 1'b0;
        valido_s = 1'b0;
        indice_s = 5'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r  <= ESPERA_REQ;
      ack_r     <= 1'b0;
      valido_r  <= 1'b0;
      erro_op_r <= 1'b0;
      indice_r  <= 5'd0;
      matriz1_r <= '0;
      matriz2_r <= '0;
      opcode_r  <= 3'b111;
      tamanho_r <= 2'b00;
    end else begin
      estado_r  <= estado_s;
      ack_r     <= ack_s;
      valido_r  <= valido_s;
      erro_op_r <= erro_op_s;
      indice_r  <= indice_s;
      matriz1_r <= matriz1_s;
      matriz2_r <= matriz2_s;
      opcode_r  <= opcode_s;
      tamanho_r <= tamanho_s;
    end
  end

  assign ack     = ack_r;
  assign valido  = valido_r;
  assign erro_op = erro_op_r;
  assign indice  = indice_r;
  assign matriz1 = matriz1_r;
  assign matriz2 = matriz2_r;
  assign opcode  = opcode_r;
  assign tamanho = tamanho_r;

endmodule

// File: tb/tb_receptor_matrizes.sv
// Self-checking bench for receptor_matrizes: drives four-phase handshakes,
// pushes each expected frame to a scoreboard queue when its stimulus is
// driven and compares it when the DUT raises valido.
module tb_receptor_matrizes;

  localparam int N = 25;
  localparam int W = 8;

  logic             clk;
  logic             reset;
  logic [31:0]      entrada;
  logic             ack;
  logic             consumir;
  logic [N*W-1:0]   matriz1;
  logic [N*W-1:0]   matriz2;
  logic [2:0]       opcode;
  logic [1:0]       tamanho;
  logic             valido;
  logic             erro_op;
  logic [4:0]       indice;

  typedef struct {
    logic [N*W-1:0] m1;
    logic [N*W-1:0] m2;
    logic [2:0]     op;
    logic [1:0]     tam;
    logic           err;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur_s;

  int n_checks = 0;
  int n_errors = 0;

  receptor_matrizes #(.N_ELEM(N), .W_ELEM(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .entrada  (entrada),
    .ack      (ack),
    .consumir (consumir),
    .matriz1  (matriz1),
    .matriz2  (matriz2),
    .opcode   (opcode),
    .tamanho  (tamanho),
    .valido   (valido),
    .erro_op  (erro_op),
    .indice   (indice)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic req, input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic [1:0] tam);
    return {req, 10'b0, tam, op, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One four-phase handshake for element k; optional hold keeps req high
  // with altered data (and a stray consumir) to show nothing is recaptured.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [1:0] tam, input int k, input logic exp_err, input int hold);
    entrada = word(1'b1, a, b, op, tam);
    tick();
    check_eq("ack_rise", 256'(ack), 256'(1'b1));
    check_eq("idx_capture", 256'(indice), 256'(k));
    check_eq("erro_capture", 256'(erro_op), 256'(exp_err));
    for (int h = 0; h < hold; h++) begin
      entrada  = word(1'b1, ~a, ~b, op, tam);
      consumir = 1'b1;
      tick();
      check_eq("hold_ack", 256'(ack), 256'(1'b1));
      check_eq("hold_idx", 256'(indice), 256'(k));
    end
    consumir = 1'b0;
    entrada  = word(1'b0, a, b, op, tam);
    tick();
    check_eq("ack_fall", 256'(ack), 256'(1'b0));
    check_eq("idx_after", 256'(indice), 256'((k < N - 1) ? k + 1 : N - 1));
    check_eq("valido_after", 256'(valido), 256'(k == N - 1));
  endtask

  // Full frame: element k carries A=base_a+k, B=base_b+k; word bad_idx uses opcode 3'b001
  task automatic send_frame(input logic [7:0] base_a, input logic [7:0] base_b, input logic [2:0] op,
                            input logic [1:0] tam, input int bad_idx, input int hold_idx, input int hold);
    frame_t m;
    logic   err_run;
    logic [2:0] wop;
    m.op  = op;
    m.tam = tam;
    m.err = (bad_idx > 0) && (bad_idx < N) && (op != 3'b001);
    for (int k = 0; k < N; k++) begin
      m.m1[k*W +: W] = base_a + 8'(k);
      m.m2[k*W +: W] = base_b + 8'(k);
    end
    exp_q.push_back(m);
    err_run = 1'b0;
    for (int k = 0; k < N; k++) begin
      wop = (k == bad_idx) ? 3'b001 : op;
      if (k == bad_idx && m.err) err_run = 1'b1;
      send_word(base_a + 8'(k), base_b + 8'(k), wop, tam, k, err_run, (k == hold_idx) ? hold : 0);
    end
  endtask

  task automatic check_frame();
    check_eq("valido_frame", 256'(valido), 256'(1'b1));
    check_eq("sb_nonempty", 256'(exp_q.size() > 0), 256'(1'b1));
    if (exp_q.size() > 0) begin
      cur_s = exp_q.pop_front();
      check_eq("matriz1", 256'(matriz1), 256'(cur_s.m1));
      check_eq("matriz2", 256'(matriz2), 256'(cur_s.m2));
      check_eq("opcode", 256'(opcode), 256'(cur_s.op));
      check_eq("tamanho", 256'(tamanho), 256'(cur_s.tam));
      check_eq("erro_op", 256'(erro_op), 256'(cur_s.err));
    end
  endtask

  task automatic consume();
    consumir = 1'b1;
    tick();
    consumir = 1'b0;
    check_eq("cons_valido", 256'(valido), 256'(1'b0));
    check_eq("cons_idx", 256'(indice), 256'(0));
    check_eq("cons_erro", 256'(erro_op), 256'(1'b0));
    check_eq("cons_m1_kept", 256'(matriz1), 256'(cur_s.m1));
    check_eq("cons_op_kept", 256'(opcode), 256'(cur_s.op));
  endtask

  initial begin
    reset    = 1'b1;
    consumir = 1'b0;
    entrada  = word(1'b1, 8'hAA, 8'hBB, 3'b000, 2'b00);
    tick();
    tick();
    check_eq("rst_ack", 256'(ack), 256'(1'b0));
    check_eq("rst_valido", 256'(valido), 256'(1'b0));
    check_eq("rst_erro", 256'(erro_op), 256'(1'b0));
    check_eq("rst_idx", 256'(indice), 256'(0));
    check_eq("rst_m1", 256'(matriz1), 256'(0));
    check_eq("rst_m2", 256'(matriz2), 256'(0));
    check_eq("rst_op", 256'(opcode), 256'(3'b111));
    check_eq("rst_tam", 256'(tamanho), 256'(2'b00));
    entrada = 32'h0000_0000;
    reset   = 1'b0;
    tick();

    // Plain full frame
    send_frame(8'd0, 8'd100, 3'b010, 2'b11, -1, -1, 0);
    check_frame();
    consume();

    // Opcode mismatch on word 7
    send_frame(8'd0, 8'd100, 3'b010, 2'b11, 7, -1, 0);
    check_frame();
    consume();

    // Long req hold on word 0 (altered data and stray consumir while held)
    send_frame(8'd50, 8'd200, 3'b101, 2'b01, -1, 0, 20);
    check_frame();

    // Back-pressure in PRONTO
    entrada = word(1'b1, 8'hFF, 8'h00, 3'b010, 2'b11);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_ack", 256'(ack), 256'(1'b0));
      check_eq("bp_m1", 256'(matriz1), 256'(cur_s.m1));
      check_eq("bp_valido", 256'(valido), 256'(1'b1));
    end
    consumir = 1'b1;
    tick();
    consumir = 1'b0;
    check_eq("bp_cons_valido", 256'(valido), 256'(1'b0));
    check_eq("bp_cons_ack", 256'(ack), 256'(1'b0));
    check_eq("bp_cons_m1", 256'(matriz1), 256'(cur_s.m1));
    tick();
    check_eq("bp_ack_late", 256'(ack), 256'(1'b1));
    check_eq("bp_elem0", 256'(matriz1[7:0]), 256'(8'hFF));
    entrada = word(1'b0, 8'hFF, 8'h00, 3'b010, 2'b11);
    tick();
    check_eq("bp_ack_fall", 256'(ack), 256'(1'b0));
    check_eq("bp_idx", 256'(indice), 256'(1));

    // Partial frame, then reset while word 12 is acknowledged and req is high
    for (int k = 1; k < 12; k++) begin
      send_word(8'(k), 8'(k), 3'b010, 2'b11, k, 1'b0, 0);
    end
    entrada = word(1'b1, 8'h12, 8'h34, 3'b010, 2'b11);
    tick();
    check_eq("mid_ack", 256'(ack), 256'(1'b1));
    check_eq("mid_idx", 256'(indice), 256'(12));
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("mrst_ack", 256'(ack), 256'(1'b0));
      check_eq("mrst_idx", 256'(indice), 256'(0));
      check_eq("mrst_m1", 256'(matriz1), 256'(0));
      check_eq("mrst_op", 256'(opcode), 256'(3'b111));
      check_eq("mrst_valido", 256'(valido), 256'(1'b0));
    end
    reset   = 1'b0;
    entrada = 32'h0000_0000;
    tick();

    // Frame after the reset starts again at element 0
    send_frame(8'd30, 8'd7, 3'b110, 2'b10, -1, -1, 0);
    check_frame();
    consume();

    check_eq("sb_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
